// File: rtl/fetch_sequencer.sv
// fetch_sequencer: step counter, IR, PC and ADDR for control_unit.
// Define STEP_LIMIT_EN for per-opcode last-step decode; else 8 steps.
module fetch_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic              done,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] bus,
    input  logic              ir_act,
    input  logic              incr_pc,
    input  logic              pc_load,
    input  logic              addr_act,
    output logic [2:0]        counter,
    output logic [9:0]        ir,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] addr,
    output logic              instr_end
);

    logic [2:0] last_step;

`ifdef STEP_LIMIT_EN
    // Final step of the instruction held in IR, from its opcode
    always_comb begin
        last_step = 3'd0;
        unique case (1'b1)
            !ir[9]:                 last_step = 3'd6;
            (ir[9:7] == 3'b100):    last_step = 3'd2;
            default:                last_step = 3'd0;
        endcase
    end
`else
    // Without opcode decode every instruction runs all eight steps
    always_comb begin
        last_step = 3'd7;
    end
`endif

    // Last step of the current instruction, or an early finish
    always_comb begin
        instr_end = run & (done | (counter == last_step));
    end

    // Step counter restarts after the final step
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            counter <= 3'd0;
        end else if (run) begin
            if (instr_end) begin
                counter <= 3'd0;
            end else begin
                counter <= counter + 3'd1;
            end
        end
    end

    // IR takes the top ten bits of memory data
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ir <= 10'd0;
        end else if (run && ir_act) begin
            ir <= din[DATA_W-1 -: 10];
        end
    end

    // PC load from bus wins over increment; increment wraps
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc <= '0;
        end else if (run) begin
            if (pc_load) begin
                pc <= bus;
            end else if (incr_pc) begin
                pc <= pc + 1'b1;
            end
        end
    end

    // ADDR captures bus directly, never the updated PC
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr <= '0;
        end else if (run && addr_act) begin
            addr <= bus;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a cycle model and checks.
// Build with or without STEP_LIMIT_EN to match the design.
module tb_fetch_sequencer;

    localparam int W = 16;
`ifdef STEP_LIMIT_EN
    localparam int ALU_L = 6;
    localparam int MV_L  = 2;
`else
    localparam int ALU_L = 7;
    localparam int MV_L  = 7;
`endif

    logic         clock    = 1'b0;
    logic         resetn   = 1'b0;
    logic         run      = 1'b0;
    logic         done     = 1'b0;
    logic [W-1:0] din      = '0;
    logic [W-1:0] bus      = '0;
    logic         ir_act   = 1'b0;
    logic         incr_pc  = 1'b0;
    logic         pc_load  = 1'b0;
    logic         addr_act = 1'b0;
    logic [2:0]   counter;
    logic [9:0]   ir;
    logic [W-1:0] pc;
    logic [W-1:0] addr;
    logic         instr_end;

    fetch_sequencer #(.DATA_W(W)) dut (
        .clock(clock), .resetn(resetn), .run(run), .done(done),
        .din(din), .bus(bus), .ir_act(ir_act), .incr_pc(incr_pc),
        .pc_load(pc_load), .addr_act(addr_act), .counter(counter),
        .ir(ir), .pc(pc), .addr(addr), .instr_end(instr_end)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int m_cnt  = 0;
    int m_ir   = 0;
    int m_pc   = 0;
    int m_addr = 0;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int last_of(input int irv);
`ifdef STEP_LIMIT_EN
        if (irv < 512) return 6;
        if ((irv >> 6) == 8 || (irv >> 6) == 9) return 2;
        return 0;
`else
        return 7;
`endif
    endfunction

    function automatic int exp_end(input int c, input int irv,
                                   input logic r, input logic d);
        return (r && (d || c == last_of(irv))) ? 1 : 0;
    endfunction

    always @(posedge clock or negedge resetn) begin : model
        int e;
        if (!resetn) begin
            m_cnt  = 0;
            m_ir   = 0;
            m_pc   = 0;
            m_addr = 0;
        end else if (run) begin
            e = exp_end(m_cnt, m_ir, run, done);
            if (ir_act) m_ir = int'(din) / 64;
            if (pc_load) m_pc = int'(bus);
            else if (incr_pc) m_pc = (m_pc + 1) % 65536;
            if (addr_act) m_addr = int'(bus);
            m_cnt = (e != 0) ? 0 : (m_cnt + 1) % 8;
        end
    end

    always @(negedge clock) begin
        chk("m_counter", int'(counter), m_cnt);
        chk("m_ir", int'(ir), m_ir);
        chk("m_pc", int'(pc), m_pc);
        chk("m_addr", int'(addr), m_addr);
        chk("m_end", int'(instr_end), exp_end(m_cnt, m_ir, run, done));
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        repeat (2) tick();
        resetn = 1'b1;
        chk("rst_counter", int'(counter), 0);
        chk("rst_ir", int'(ir), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_end", int'(instr_end), 0);

        run    = 1'b1;
        din    = 16'h0000;
        ir_act = 1'b1;
        for (int i = 0; i <= ALU_L; i++) begin
            chk("alu_cnt", int'(counter), i);
            chk("alu_end", int'(instr_end), (i == ALU_L) ? 1 : 0);
            tick();
            ir_act = 1'b0;
        end
        chk("alu_wrap", int'(counter), 0);

        din    = 16'h8000;
        ir_act = 1'b1;
        for (int i = 0; i <= MV_L; i++) begin
            chk("mv_cnt", int'(counter), i);
            chk("mv_end", int'(instr_end), (i == MV_L) ? 1 : 0);
            tick();
            ir_act = 1'b0;
            if (i == 0) chk("mv_ir", int'(ir), 'h200);
        end
        chk("mv_wrap", int'(counter), 0);

        din    = 16'h0000;
        ir_act = 1'b1;
        tick();
        ir_act = 1'b0;
        repeat (2) tick();
        chk("stall_pre", int'(counter), 3);
        run = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_cnt", int'(counter), 3);
            chk("stall_end", int'(instr_end), 0);
        end
        run = 1'b1;
        tick();
        chk("resume_cnt", int'(counter), 4);
        for (int k = 0; k < 10 && counter != 3'd0; k++) tick();
        chk("drain", int'(counter), 0);

        tick();
        chk("done_pre", int'(counter), 1);
        done = 1'b1;
        #1;
        chk("done_end", int'(instr_end), 1);
        tick();
        chk("done_cnt", int'(counter), 0);
        done = 1'b0;

        pc_load = 1'b1;
        bus     = 16'hFFFF;
        tick();
        chk("pc_ffff", int'(pc), 'hFFFF);
        pc_load = 1'b0;
        incr_pc = 1'b1;
        tick();
        chk("pc_wrap", int'(pc), 0);
        pc_load = 1'b1;
        bus     = 16'h0040;
        tick();
        chk("pc_prio", int'(pc), 'h40);
        pc_load  = 1'b0;
        incr_pc  = 1'b0;
        addr_act = 1'b1;
        bus      = 16'h00A5;
        tick();
        chk("addr_ld", int'(addr), 'hA5);
        chk("addr_pc", int'(pc), 'h40);
        addr_act = 1'b0;

        pc_load = 1'b1;
        bus     = 16'h0012;
        tick();
        pc_load = 1'b0;
        for (int k = 0; k < 10 && counter != 3'd4; k++) tick();
        chk("mid_cnt", int'(counter), 4);
        chk("mid_pc", int'(pc), 'h12);
        resetn = 1'b0;
        #1;
        chk("arst_cnt", int'(counter), 0);
        chk("arst_ir", int'(ir), 0);
        chk("arst_pc", int'(pc), 0);
        chk("arst_addr", int'(addr), 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst", int'(counter), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-sequencing stage upstream of `control_unit`. It holds the step counter, the instruction register (IR), the program counter (PC) and the memory address register (ADDR). It supplies `control_unit` with `counter` and `ir`, and executes the `ir_act`, `incr_pc` and `addr_act` strobes that `control_unit` produces. It also detects the last step of each instruction, so the counter restarts at step 0 for the next fetch.

## Interface
- `DATA_W`, 16: width of the bus, memory data, PC and ADDR.
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  enables sequencing; low freezes all state.
- `done`  in  1  forces end of the current instruction.
- `din`  in  DATA_W  memory read data; IR source.
- `bus`  in  DATA_W  datapath bus; PC and ADDR source.
- `ir_act`  in  1  load IR.
- `incr_pc`  in  1  PC increment request.
- `pc_load`  in  1  load PC from `bus` (R7 write enable).
- `addr_act`  in  1  load ADDR from `bus`.
- `counter`  out  3  current step, registered.
- `ir`  out  10  instruction register, registered.
- `pc`  out  DATA_W  program counter, registered.
- `addr`  out  DATA_W  memory address, registered.
- `instr_end`  out  1  combinational; high during the last step of the current instruction.

## Operation
- **Reset:** `resetn` low clears `counter`, `ir`, `pc` and `addr` to 0 immediately, without waiting for a clock edge. `instr_end` then follows from that state.
- **Stall:** when `run`=0, no register changes and `instr_end`=0.
- **IR load:** with `run`=1 and `ir_act`=1, `ir <= din[DATA_W-1 -: 10]`.
- **PC update:**
  - `pc_load`=1: `pc <= bus`.
  - `incr_pc`=1 and `pc_load`=0: `pc <= pc + 1`. The add is modulo 2^DATA_W, so 0xFFFF wraps to 0x0000.
  - `pc_load` has priority when both are high.
- **ADDR load:** with `addr_act`=1, `addr <= bus`. Independent of PC updates; ADDR captures `bus` as sampled, not the updated PC.
- **Last-step decode** (from `ir[9:6]`, with `STEP_LIMIT_EN` defined):
  - `0xxx` (ALU): last step 6.
  - `1000` (mv) and `1001` (mvi): last step 2.
  - All other opcodes: last step 0.
- **instr_end:** high when `run`=1 and either `done`=1 or `counter` equals the last step.
- **Counter:**
  - When `run`=1: if `instr_end`, `counter <= 0`; else `counter <= counter + 1`.
  - 3-bit value; 7 wraps to 0.
- **Simultaneous events:** `done` and a last-step match give the same single reset to 0. An `ir_act` in the final step of an instruction still loads the IR.

## Timing
- `counter`, `ir`, `pc` and `addr` are registered with zero combinational path from inputs. `instr_end` is combinational from `counter`, `ir`, `run` and `done`.
- The IR loaded at the edge ending step 0 is valid throughout step 1, when `control_unit` decodes it.
- An ALU instruction occupies 7 cycles (steps 0-6). mv/mvi occupy 3 cycles (steps 0-2). Undefined opcodes occupy 1 cycle (step 0 only).
- PC increment or load, and ADDR load, are visible one cycle after the strobe.
- **Mid-instruction reset:** asynchronous clear. After `resetn` rises, the first rising edge with `run`=1 advances `counter` 0→1, exactly as a normal step 0.
- **Stall mid-instruction:** `run` low holds `counter`. Resuming continues from the held step without skipping or repeating it.

## Configuration
- `STEP_LIMIT_EN` defined: last-step decode active as in Operation.
- `STEP_LIMIT_EN` undefined:
  - No opcode decode; `instr_end` = `run & (done | counter==7)`.
  - Every instruction spans 8 steps unless `done` ends it early.
  - IR, PC and ADDR behaviour is unchanged.

## Test plan
- **Reset mid-operation:** assert `resetn`=0 while `counter`=4, `pc`=0x0012 → `counter`, `ir`, `pc` and `addr` read 0 before the next clock edge.
- **ALU instruction:** `din`=0x0000 (IR=0), `ir_act` at step 0, `run`=1 → `counter` sequence 0,1,2,3,4,5,6,0; `instr_end` high only at step 6.
- **mv instruction:** `din`=0x8000 (IR=`1000000000`), `ir_act` at step 0 → `counter` 0,1,2,0. With `STEP_LIMIT_EN` undefined → `counter` 0..7,0.
- **Stall and done:** `run`=0 for 3 cycles at step 3 → `counter` holds 3, then resumes at 4. `done`=1 at step 1 → next `counter`=0.
- **PC priority and wrap:** `pc`=0xFFFF, `incr_pc`=1 → `pc`=0x0000. Then `incr_pc`=1 with `pc_load`=1, `bus`=0x0040 → `pc`=0x0040.
- **ADDR load:** `addr_act`=1 with `bus`=0x00A5 → `addr`=0x00A5 next cycle, `pc` unchanged.
